// File: rtl/run_host.sv
// Host-side sequencer: holds the core in init, releases it on go, times the run
// until halt or watchdog, then streams a window of data memory out over valid/ready.
module run_host #(
    parameter int unsigned START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'd4000,
    parameter logic [7:0]  DUMP_BASE    = 8'd0,
    parameter int unsigned DUMP_LEN     = 8
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        go,
    output logic        start,
    input  logic        halt,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [7:0]  out_addr,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic [15:0] cycles
);

    localparam int unsigned      SCW        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0]   START_LAST = SCW'(START_CYCLES - 1);
    localparam logic [8:0]       IDX_LAST   = 9'(DUMP_LEN - 1);
    localparam logic [15:0]      CYC_LAST   = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {IDLE, START, RUN, FETCH, PRESENT, DONE} state_t;

    state_t         state_q;
    logic [SCW-1:0] scnt_q;
    logic [8:0]     idx_q;      // 9 bits so that DUMP_LEN=256 still reaches IDX_LAST
    logic [15:0]    cycles_q;
    logic           timed_out_q;
    logic           start_q, busy_q, done_q, mem_rd_q, out_valid_q;
    logic [7:0]     mem_addr_q, out_data_q, out_addr_q;

    // NOTE: every register here is updated with <= so all branches see pre-edge values.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            idx_q       <= '0;
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
            start_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        state_q     <= START;
                        scnt_q      <= '0;
                        idx_q       <= '0;
                        cycles_q    <= '0;
                        timed_out_q <= 1'b0;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                START: begin
                    if (scnt_q == START_LAST) begin
                        state_q <= RUN;
                        start_q <= 1'b0;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cycles_q <= cycles_q + 16'd1;
                    // halt takes priority over the watchdog when both hit together
                    if (halt || (cycles_q == CYC_LAST)) begin
                        state_q     <= FETCH;
                        timed_out_q <= ~halt;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= DUMP_BASE + idx_q[7:0];
                    end
                end
                FETCH: begin
                    state_q     <= PRESENT;
                    out_data_q  <= mem_dout;
                    out_addr_q  <= mem_addr_q;
                    out_valid_q <= 1'b1;
                    mem_rd_q    <= 1'b0;
                    mem_addr_q  <= '0;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            idx_q      <= idx_q + 9'd1;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= DUMP_BASE + idx_q[7:0] + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    start_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    mem_rd_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    mem_addr_q  <= '0;
                end
            endcase
        end
    end

    assign start     = start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign timed_out = timed_out_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_run_host.sv
// Directed bench for run_host: two instances (base 0 and base 254) share stimulus;
// expected dump words are queued at launch and popped as each word is transferred.
module tb_run_host;

    logic CLK = 1'b0;
    logic reset_n, go, halt, out_ready;
    always #5 CLK = ~CLK;

    logic [7:0] mem [256];

    logic        start_a, mem_rd_a, out_valid_a, busy_a, done_a, timed_out_a;
    logic [7:0]  mem_addr_a, mem_dout_a, out_data_a, out_addr_a;
    logic [15:0] cycles_a;
    logic        start_b, mem_rd_b, out_valid_b, busy_b, done_b, timed_out_b;
    logic [7:0]  mem_addr_b, mem_dout_b, out_data_b, out_addr_b;
    logic [15:0] cycles_b;

    assign mem_dout_a = mem[mem_addr_a];
    assign mem_dout_b = mem[mem_addr_b];

    run_host #(.START_CYCLES(2), .TIMEOUT(16'd100), .DUMP_BASE(8'd0), .DUMP_LEN(4)) dut_a (
        .CLK(CLK), .reset_n(reset_n), .go(go), .start(start_a), .halt(halt),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_dout(mem_dout_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_addr(out_addr_a), .busy(busy_a), .done(done_a),
        .timed_out(timed_out_a), .cycles(cycles_a)
    );

    run_host #(.START_CYCLES(2), .TIMEOUT(16'd100), .DUMP_BASE(8'd254), .DUMP_LEN(4)) dut_b (
        .CLK(CLK), .reset_n(reset_n), .go(go), .start(start_b), .halt(halt),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_dout(mem_dout_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_addr(out_addr_b), .busy(busy_b), .done(done_b),
        .timed_out(timed_out_b), .cycles(cycles_b)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } word_t;

    word_t sb_a[$];
    word_t sb_b[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        logic [7:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 8'(i);
            sb_a.push_back({a, mem[a]});
            a = 8'(254 + i);
            sb_b.push_back({a, mem[a]});
        end
    endtask

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic launch(input bit halt_in_start);
        int n;
        push_expected();
        go = 1'b1;
        halt = halt_in_start;
        @(negedge CLK);
        go = 1'b0;
        check("start_cycles_cleared", cycles_a, 0);
        check("start_timed_out_cleared", timed_out_a, 0);
        check("start_busy", busy_a, 1);
        check("start_done_low", done_a, 0);
        n = 0;
        while (start_a === 1'b1 && n < 20) begin
            n++;
            @(negedge CLK);
        end
        halt = 1'b0;
        check("start_width", n, 2);
        check("run_busy", busy_a, 1);
    endtask

    // Raises halt in RUN cycle k; returns at the negedge of FETCH.
    task automatic run_halt(input int k);
        repeat (k - 1) @(negedge CLK);
        halt = 1'b1;
        @(negedge CLK);
        halt = 1'b0;
        check("fetch_mem_rd", mem_rd_a, 1);
        check("fetch_cycles", cycles_a, k);
        check("fetch_timed_out", timed_out_a, 0);
        check("fetch_addr_a", mem_addr_a, 0);
        check("fetch_addr_b", mem_addr_b, 254);
    endtask

    // Drains four words from both instances; stall_idx gets out_ready low for stall_n cycles.
    task automatic dump(input int stall_idx, input int stall_n);
        int words, cyc, last, stall;
        logic [7:0] hold_d, hold_a;
        word_t w;
        words = 0; cyc = 0; last = -1; stall = stall_n;
        hold_d = '0; hold_a = '0;
        out_ready = 1'b1;
        while (words < 4 && cyc < 100) begin
            if (words == stall_idx && stall > 0 && (out_valid_a || stall < stall_n)) begin
                check("stall_valid", out_valid_a, 1);
                if (stall < stall_n) begin
                    check("stall_data_stable", out_data_a, hold_d);
                    check("stall_addr_stable", out_addr_a, hold_a);
                end
                hold_d = out_data_a;
                hold_a = out_addr_a;
                stall--;
                out_ready = 1'b0;
            end else if (out_valid_a) begin
                out_ready = 1'b1;
                if (sb_a.size() > 0) begin
                    w = sb_a.pop_front();
                    check("word_data_a", out_data_a, w.data);
                    check("word_addr_a", out_addr_a, w.addr);
                end
                check("word_valid_b", out_valid_b, 1);
                if (sb_b.size() > 0) begin
                    w = sb_b.pop_front();
                    check("word_data_b", out_data_b, w.data);
                    check("word_addr_b", out_addr_b, w.addr);
                end
                if (stall_n == 0 && last >= 0) check("word_gap", cyc - last, 2);
                last = cyc;
                words++;
            end
            @(negedge CLK);
            cyc++;
        end
        check("dump_words", words, 4);
        check("dump_sb_empty", sb_a.size() + sb_b.size(), 0);
        check("done_flag", done_a, 1);
        check("done_busy", busy_a, 0);
        check("done_start", start_a, 0);
        check("done_valid", out_valid_a, 0);
        check("done_flag_b", done_b, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'd11; mem[1] = 8'd22; mem[2] = 8'd33; mem[3] = 8'd44;
        reset_n = 1'b0; go = 1'b0; halt = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_start", start_a, 1);
        check("rst_mem_rd", mem_rd_a, 0);
        check("rst_mem_addr", mem_addr_a, 0);
        check("rst_valid", out_valid_a, 0);
        check("rst_data", out_data_a, 0);
        check("rst_addr", out_addr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_timed_out", timed_out_a, 0);
        check("rst_cycles", cycles_a, 0);
        check("rst_mem_addr_b", mem_addr_b, 0);
        reset_n = 1'b1;
        @(negedge CLK);
        check("idle_start", start_a, 1);

        // Run 1: halt in RUN cycle 10 (halt during START ignored), ready held high.
        launch(1'b1);
        run_halt(10);
        dump(-1, 0);
        check("run1_cycles", cycles_a, 10);
        check("run1_timed_out", timed_out_a, 0);
        halt = 1'b1;
        @(negedge CLK);
        halt = 1'b0;
        check("done_ignores_halt", done_a, 1);
        check("done_cycles_hold", cycles_a, 10);

        // Run 2: watchdog; a go pulse mid-run is ignored; backpressure on word 2.
        launch(1'b0);
        n = 0;
        while (mem_rd_a !== 1'b1 && n < 300) begin
            go = (n == 50);
            n++;
            @(negedge CLK);
        end
        go = 1'b0;
        check("timeout_run_len", n, 100);
        check("timeout_cycles", cycles_a, 100);
        check("timeout_flag", timed_out_a, 1);
        dump(2, 5);
        check("timeout_flag_hold", timed_out_a, 1);

        // Run 3: halt coincides with the watchdog cycle; halt wins.
        launch(1'b0);
        run_halt(100);
        dump(-1, 0);
        check("tie_cycles", cycles_a, 100);

        // Run 4: reset asserted while a word is being presented.
        launch(1'b0);
        run_halt(3);
        out_ready = 1'b0;
        @(negedge CLK);
        check("pre_rst_valid", out_valid_a, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_start", start_a, 1);
        check("async_rst_valid", out_valid_a, 0);
        check("async_rst_busy", busy_a, 0);
        check("async_rst_cycles", cycles_a, 0);
        check("async_rst_data", out_data_a, 0);
        @(negedge CLK);
        reset_n = 1'b1;
        sb_a.delete();
        sb_b.delete();
        @(negedge CLK);

        // Run 5: fresh run from IDLE after reset.
        launch(1'b0);
        run_halt(1);
        dump(-1, 0);
        check("run5_cycles", cycles_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_host.md
# run_host

Host-side sequencer for the processor's start/halt interface and data memory read path. It holds the core in init and, on `go`, releases it. It then counts cycles until `halt` or a watchdog timeout. Finally it reads back a window of data memory and streams each word out over a valid/ready port. It sits between the bench or host and the processor top level, driving the core's `start` and consuming its `halt`.

## Interface
- `START_CYCLES`, 2: minimum cycles `start` is held high after `go` (≥1)
- `TIMEOUT`, 16'd4000: run-cycle limit before forced stop (≥1)
- `DUMP_BASE`, 8'd0: first data memory address read back
- `DUMP_LEN`, 8: number of words read back (1..256)

- `CLK` in 1: clock, posedge only
- `reset_n` in 1: asynchronous reset, active-low
- `go` in 1: request a run; sampled only in IDLE or DONE
- `start` out 1: to core init/reset, active high
- `halt` in 1: core done flag
- `mem_addr` out 8: data memory read address
- `mem_rd` out 1: data memory read enable
- `mem_dout` in 8: data memory read data, combinational from `mem_addr`
- `out_valid` out 1: read-back word available
- `out_ready` in 1: consumer accepts word
- `out_data` out 8: read-back word
- `out_addr` out 8: address of `out_data`
- `busy` out 1: high in START, RUN, FETCH, PRESENT
- `done` out 1: high in DONE
- `timed_out` out 1: last run ended by watchdog, not `halt`
- `cycles` out 16: run-cycle count of current/last run

## Operation
- States: IDLE, START, RUN, FETCH, PRESENT, DONE.
- IDLE: `start`=1 (core held in init). `go` -> START, with the start counter, `cycles`, `timed_out` and the dump index all cleared.
- START: `start`=1 for exactly START_CYCLES cycles, then -> RUN.
- RUN: `start`=0. `cycles` increments each RUN cycle.
  - `halt`=1 -> FETCH, `timed_out`=0.
  - Else if `cycles`==TIMEOUT-1 -> FETCH, `timed_out`=1; final `cycles`=TIMEOUT.
  - `halt` and timeout in the same cycle: `halt` wins, `timed_out`=0.
- FETCH: `mem_rd`=1, `mem_addr`=DUMP_BASE+idx (8-bit, wraps 255->0). Data is captured into `out_data`/`out_addr` at the cycle end, then -> PRESENT.
- PRESENT: `out_valid`=1. `out_data`/`out_addr` stay stable until `out_valid`&&`out_ready`.
  - On transfer, if idx==DUMP_LEN-1 -> DONE; else idx+1 -> FETCH.
  - `out_ready` may be held high; throughput is 1 word per 2 cycles.
- DONE: `start`=0 (core stays halted; data memory is not reset). `done`=1. `cycles`/`timed_out` hold. `go` -> START.
- `go` in START/RUN/FETCH/PRESENT is ignored. `halt` outside RUN is ignored.
- `start` is 0 throughout FETCH/PRESENT/DONE, because the core's data memory clears on `start`.
- idx is 9 bits internally so DUMP_LEN=256 terminates.

## Timing
- Reset (`reset_n`=0, asynchronous, any state including mid-run or mid-dump): state=IDLE, `start`=1, `mem_rd`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `busy`=0, `done`=0, `timed_out`=0, `cycles`=0.
- All outputs are registered or decoded from registered state only; no combinational path from `go`, `halt` or `out_ready` to any output.
- `go` high at edge N (IDLE) -> `start` high through edge N+START_CYCLES -> first RUN cycle follows; `start` low from that cycle.
- `halt` high in RUN cycle k -> FETCH next cycle -> `out_valid` high the cycle after.
- Word i transfer at edge M -> word i+1 `out_valid` at the cycle after M+1.

## Test plan
- START_CYCLES=2, TIMEOUT=100, DUMP_LEN=4, base 0, memory {11,22,33,44}; `go` pulse; `halt` after 10 RUN cycles; `out_ready`=1 -> `start` high 2 cycles after `go`, `cycles`=10, 4 words 11,22,33,44 with `out_addr` 0..3, `done`=1, `timed_out`=0.
- `halt` never asserted, TIMEOUT=100 -> `cycles`=100, `timed_out`=1, dump still completes, `done`=1.
- `halt` rises on the RUN cycle where `cycles`=TIMEOUT-1 -> `timed_out`=0, `cycles`=TIMEOUT.
- Backpressure: `out_ready` low for 5 cycles on word 2 -> `out_valid` stays high, `out_data`/`out_addr` unchanged, no word skipped or duplicated.
- DUMP_BASE=254, DUMP_LEN=4 -> `out_addr` sequence 254,255,0,1.
- `reset_n` low mid-PRESENT, then `go` in DONE after a full run -> reset gives IDLE outputs immediately (`start`=1, `out_valid`=0); second run restarts with `cycles` cleared and `timed_out` cleared.
